// File: rtl/wr_en_ctrl.sv
// Write-enable controller: 2-entry request FIFO, one issue register, and a
// falling-edge launched one-hot enable/data bus for a gated-enable flop array.
module wr_en_ctrl #(
  parameter int WORDS = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_data,
  output logic             req_ready,
  output logic [WORDS-1:0] wr_en,
  output logic [DW-1:0]    wr_data,
  output logic [7:0]       wr_count,
  output logic             err
);

  localparam logic [AW:0] WORDS_L = (AW+1)'(WORDS);

  logic [AW-1:0]    fifo_addr_q [2];
  logic [DW-1:0]    fifo_data_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             rst_q;

  logic             issue_vld_q, issue_vld_d;
  logic [AW-1:0]    issue_addr_q, issue_addr_d;
  logic [DW-1:0]    issue_data_q, issue_data_d;

  logic [7:0]       count_q, count_d;
  logic             err_q, err_d;

  logic [WORDS-1:0] wr_en_q, wr_en_d;
  logic [DW-1:0]    wr_data_q;

  logic             push, pop;
  logic             req_in_range, issue_in_range;

  // rst_q holds ready low for the cycle following every reset edge.
  assign req_ready      = !rst_q && (occ_q < 2'd2);
  assign push           = req_valid && req_ready;
  assign pop            = (occ_q != 2'd0);
  assign req_in_range   = ({1'b0, req_addr} < WORDS_L);
  assign issue_in_range = ({1'b0, issue_addr_q} < WORDS_L);

  always_comb begin
    occ_d        = occ_q + 2'(push) - 2'(pop);
    wr_ptr_d     = push ? !wr_ptr_q : wr_ptr_q;
    rd_ptr_d     = pop  ? !rd_ptr_q : rd_ptr_q;
    issue_vld_d  = pop;
    issue_addr_d = issue_addr_q;
    issue_data_d = issue_data_q;
    if (pop) begin
      issue_addr_d = fifo_addr_q[rd_ptr_q];
      issue_data_d = fifo_data_q[rd_ptr_q];
    end
    count_d = count_q + 8'(issue_vld_q && issue_in_range);
    err_d   = err_q || (push && !req_in_range);
  end

  always_comb begin
    wr_en_d = '0;
    if (issue_vld_q && issue_in_range) begin
      wr_en_d = WORDS'(1) << issue_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      issue_vld_q <= 1'b0;
      count_q     <= 8'd0;
      err_q       <= 1'b0;
      rst_q       <= 1'b1;
    end else begin
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      issue_vld_q <= issue_vld_d;
      count_q     <= count_d;
      err_q       <= err_d;
      rst_q       <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    issue_addr_q <= issue_addr_d;
    issue_data_q <= issue_data_d;
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= req_addr;
      fifo_data_q[wr_ptr_q] <= req_data;
    end
  end

  // Launch on the falling edge so enables are settled before the array's rising edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      wr_en_q   <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      if (issue_vld_q) begin
        wr_data_q <= issue_data_q;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign wr_count = count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_wr_en_ctrl.sv
// Scoreboard bench for wr_en_ctrl: stimulus pushes expected writes, a
// falling-edge monitor pops and compares enables, data, count, err and ready.
module tb_wr_en_ctrl;
  localparam int WORDS = 6;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [DW-1:0]    req_data = '0;
  logic             req_ready;
  logic [WORDS-1:0] wr_en;
  logic [DW-1:0]    wr_data;
  logic [7:0]       wr_count;
  logic             err;

  wr_en_ctrl #(.WORDS(WORDS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en),
    .wr_data(wr_data), .wr_count(wr_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  bit            started  = 0;
  bit            acc_s    = 0;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  int            model_occ = 0;
  bit            model_rdy = 0;
  int            model_cnt = 0;
  bit            model_err = 0;
  bit            commit_pend = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model advanced at each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      started     = 1;
      sb.delete();
      model_occ   = 0;
      model_rdy   = 0;
      model_cnt   = 0;
      model_err   = 0;
      commit_pend = 0;
    end else if (started) begin
      if (commit_pend) model_cnt = (model_cnt + 1) % 256;
      commit_pend = 0;
      if (model_occ > 0) model_occ--;
      if (acc_s) begin
        model_occ++;
        if (int'(acc_addr) < WORDS) sb.push_back('{addr: acc_addr, data: acc_data, cyc: cyc});
        else model_err = 1;
      end
      model_rdy = (model_occ < 2);
    end
  end

  // Monitor: every falling edge, the write due this cycle (accepted at T, shown after T+1).
  always @(negedge clk) begin
    exp_t e;
    #1;
    acc_s    = started && req_valid && (req_ready === 1'b1);
    acc_addr = req_addr;
    acc_data = req_data;
    if (started) begin
      check("req_ready", 32'(req_ready), 32'(model_rdy));
      check("wr_count", 32'(wr_count), 32'(model_cnt));
      check("err", 32'(err), 32'(model_err));
      if (rst) begin
        check("wr_en_in_reset", 32'(wr_en), 32'd0);
      end else if (sb.size() > 0 && sb[0].cyc + 1 <= cyc) begin
        e = sb.pop_front();
        check("wr_en_onehot", 32'(wr_en), 32'd1 << e.addr);
        check("wr_data", 32'(wr_data), 32'(e.data));
        commit_pend = 1;
      end else begin
        check("wr_en_idle", 32'(wr_en), 32'd0);
      end
    end
  end

  always @(wr_en) begin
    if (started) begin
      n_checks++;
      if (clk === 1'b1) begin
        n_fail++;
        $display("FAIL wr_en_glitch: changed to 0x%0h while clk high (cycle %0d)", wr_en, cyc);
      end
    end
  end

  task automatic drive(input bit v, input int a, input int d, input bit r);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = AW'(a);
    req_data  = DW'(d);
    rst       = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    drive(1, 3, 8'hA5, 0);
    idle(4);
    check("single_count", 32'(wr_count), 32'd1);
    check("single_data", 32'(wr_data), 32'hA5);

    drive(1, 0, 8'h10, 0);
    drive(1, 1, 8'h21, 0);
    drive(1, 2, 8'h32, 0);
    idle(4);
    check("b2b_count", 32'(wr_count), 32'd4);

    drive(1, 7, 8'h55, 0);
    idle(3);
    check("oor_err", 32'(err), 32'd1);
    check("oor_count", 32'(wr_count), 32'd4);
    drive(1, 6, 8'h66, 0);
    drive(1, 5, 8'h77, 0);
    idle(3);
    check("after_oor_count", 32'(wr_count), 32'd5);
    check("after_oor_data", 32'(wr_data), 32'h77);

    drive(1, 1, 8'h11, 0);
    drive(1, 2, 8'h22, 0);
    drive(0, 0, 0, 1);
    idle(3);
    check("rst_mid_count", 32'(wr_count), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    check("rst_mid_wr_en", 32'(wr_en), 32'd0);

    repeat (300) drive($urandom_range(0, 1), $urandom_range(0, 7),
                       $urandom_range(0, 255), ($urandom_range(0, 49) == 0));
    idle(4);

    drive(0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 256; i++) drive(1, i % WORDS, $urandom_range(0, 255), 0);
    idle(4);
    check("wrap_count", 32'(wr_count), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wr_en_ctrl.md
WR_EN_CTRL -- requirements
Module: wr_en_ctrl

Interface
REQ-001 Parameters SHALL be: WORDS, default 8, number of storage words; AW, default 3, address width; DW, default 8, data width.
REQ-002 clk  input  1  single clock; the storage array of gated-enable flops captures on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  a write request is present.
REQ-005 req_addr  input  AW  target word index.
REQ-006 req_data  input  DW  write data.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 wr_en  output  WORDS  one-hot per-word write enable to the storage flops.
REQ-009 wr_data  output  DW  data bus to the D inputs of all storage words.
REQ-010 wr_count  output  8  number of writes committed to storage.
REQ-011 err  output  1  sticky flag: an out-of-range address was received.

Function
REQ-012 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; there is no other acceptance path.
REQ-013 Accepted requests SHALL enter a 2-entry in-order FIFO; req_ready = (occupancy < 2), derived from registered state only, never from req_valid.
REQ-014 Issue stage: on each rising edge where the FIFO is non-empty, the head SHALL be popped into an issue register (issue_vld, issue_addr, issue_data); otherwise issue_vld SHALL clear.
REQ-015 A push and a pop on the same edge SHALL leave occupancy unchanged, with order preserved.
REQ-016 wr_en and wr_data SHALL be registered on the falling edge of clk from the issue register, so they are stable across the whole clk-high phase; on a falling edge, wr_en = one-hot(issue_addr) if issue_vld else all zero.
REQ-017 wr_data SHALL hold its last value when issue_vld is 0.
REQ-018 Latency: for a request accepted at rising edge T into an empty FIFO, wr_en SHALL assert at the falling edge after T+1, the storage SHALL capture at rising edge T+2, and wr_en SHALL deassert at the next falling edge unless a following write is issued.
REQ-019 Throughput SHALL be one write per cycle with back-to-back requests; consecutive writes to different words SHALL switch the one-hot bit with no idle cycle between them.
REQ-020 At most one wr_en bit SHALL be high at any time; wr_en SHALL never change while clk is high.
REQ-021 A request with req_addr >= WORDS SHALL still be accepted, SHALL set err, SHALL not be written (no wr_en bit), and SHALL not increment wr_count.
REQ-022 wr_count SHALL increment by 1 on each rising edge where an in-range write is issued; it SHALL wrap 255 -> 0.
REQ-023 err SHALL stay 1 until reset.

Reset
REQ-024 While rst is high at a rising edge, the block SHALL clear the FIFO (occupancy 0), issue_vld, wr_count (0) and err (0); req_ready SHALL be 0 in that cycle and 1 from the first edge after rst falls.
REQ-025 The falling-edge stage SHALL force wr_en to all zero whenever rst is high; wr_data resets to 0.
REQ-026 A reset asserted mid-operation SHALL discard every queued and in-issue request; no write is committed after the reset edge.

Verification
REQ-027 Single write: after reset, addr=3, data=0xA5 accepted at edge T -> wr_en=8'b0000_1000 from the falling edge after T+1 until the falling edge after T+2; wr_data=0xA5; wr_count=1.
REQ-028 Back-to-back: addr 0,1,2 with req_valid held for 3 cycles -> req_ready stays 1; wr_en walks 0x01,0x02,0x04 on consecutive cycles; wr_count=3.
REQ-029 Full FIFO: issue stage stalled by a forced-full condition, 3 requests offered -> req_ready=0 after the 2nd; the 3rd is accepted only after a pop; order is preserved.
REQ-030 Out of range: WORDS=6, addr=7 -> err=1, wr_en stays 0, wr_count unchanged; a following in-range write still commits.
REQ-031 Reset mid-burst: rst pulsed while 2 requests are queued -> wr_en=0 at the next falling edge; no write is committed; wr_count=0; err=0.
REQ-032 Wrap: 256 in-range writes -> wr_count=0; glitch check confirms wr_en is never changed while clk=1.
